// File: rtl/tdc_fine_measure_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_fine_measure_pkg
//  Description : Shared constants and FSM state encoding for the fine TDC
//                measurement stage and its delay-line sub-module.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdc_fine_measure_pkg;

  // Tap index exported for coarse/fine arbitration.
  localparam int TOLERANCE_COARSE = 32;

  // CARRY4 static configuration: every mux propagates, DI tied low.
  localparam logic [3:0] c_carry_s  = 4'b1111;
  localparam logic [3:0] c_carry_di = 4'b0000;

  // Measurement FSM state encoding.
  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_START = 2'd1,
    S_WAIT_STOP  = 2'd2,
    S_DONE       = 2'd3
  } tdc_state_e;

endpackage
`default_nettype wire

// File: rtl/tdc_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_delay_line
//  Description : Carry-chain delay line (NUM_TAPS/4 CARRY4 cells, CYINIT=hit,
//                S=1111, DI=0000) followed by the first sampling FF column.
//  Revision    : 1.0 - initial release
// ============================================================================
(* keep_hierarchy = "yes" *)
module tdc_delay_line
  import tdc_fine_measure_pkg::*;
#(
  parameter int NUM_TAPS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hit,
  output logic [NUM_TAPS-1:0] taps
);

  (* dont_touch = "true" *) logic [NUM_TAPS-1:0] w_chain;
  (* dont_touch = "true" *) logic [NUM_TAPS-1:0] w_co;
  (* dont_touch = "true" *) logic [NUM_TAPS-1:0] r_s1;
  logic                                         w_carry;

  // Ripple the hit through the carry muxes; each CO output is one tap.
  always_comb begin
    w_carry = hit;
    w_chain = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      w_carry    = c_carry_s[i[1:0]] ? w_carry : c_carry_di[i[1:0]];
      w_chain[i] = w_carry;
    end
  end

  assign w_co = w_chain;

  // First sampling column: FDCE per tap, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
    end else begin
      r_s1 <= w_co;
    end
  end

  assign taps = r_s1;

endmodule
`default_nettype wire

// File: rtl/tdc_fine_measure.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_fine_measure
//  Description : Fine TDC stage. Samples the delay line twice, detects start
//                and stop edges internally, encodes them by popcount, counts
//                coarse cycles between them and hands one record per armed
//                measurement downstream over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdc_fine_measure
  import tdc_fine_measure_pkg::*;
#(
  parameter int NUM_TAPS = 64,
  parameter int CODE_W   = $clog2(NUM_TAPS + 1),
  parameter int COARSE_W = 16,
  parameter int ARB_TAP  = TOLERANCE_COARSE
) (
  input  logic                clk,
  input  logic                iRst_n,
  input  logic                iHit,
  input  logic                iDebugMode,
  input  logic                iDebugHit,
  input  logic                iArm,
  input  logic                iReady,
  output logic                oValid,
  output logic [CODE_W-1:0]   oStartCode,
  output logic [CODE_W-1:0]   oStopCode,
  output logic [COARSE_W-1:0] oCoarse,
  output logic                oTimeout,
  output logic                oBusy,
  output logic                oArbStart,
  output logic                oArbStop
);

  // Number of set taps; a single bubble moves the result by at most one.
  function automatic logic [CODE_W-1:0] popcount(input logic [NUM_TAPS-1:0] word);
    logic [CODE_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      cnt = cnt + CODE_W'(word[i]);
    end
    return cnt;
  endfunction

  logic                w_hit;
  logic [NUM_TAPS-1:0] w_taps;
  logic [NUM_TAPS-1:0] r_s2;
  logic [NUM_TAPS-1:0] r_s2p;
  logic                w_event;
  logic                r_evt;
  logic [CODE_W-1:0]   r_evt_code;
  logic                r_evt_arb;

  tdc_state_e          r_state;
  logic                r_valid;
  logic [CODE_W-1:0]   r_start_code;
  logic [CODE_W-1:0]   r_stop_code;
  logic [COARSE_W-1:0] r_coarse;
  logic [COARSE_W-1:0] w_coarse_inc;
  logic                r_timeout;
  logic                r_busy;
  logic                r_arb_start;
  logic                r_arb_stop;

  // Hit source select is purely combinational so debug hits see the same chain.
  assign w_hit = iDebugMode ? iDebugHit : iHit;

  tdc_delay_line #(
    .NUM_TAPS (NUM_TAPS)
  ) u_delay_line (
    .clk   (clk),
    .rst_n (iRst_n),
    .hit   (w_hit),
    .taps  (w_taps)
  );

  // An edge needs an all-zero word in front of it, so a stop implies the hit fell.
  assign w_event = (r_s2 != '0) && (r_s2p == '0);

  // Second sampling stage, previous-word history and registered edge event.
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_s2       <= '0;
      r_s2p      <= '0;
      r_evt      <= 1'b0;
      r_evt_code <= '0;
      r_evt_arb  <= 1'b0;
    end else begin
      r_s2       <= w_taps;
      r_s2p      <= r_s2;
      r_evt      <= w_event;
      r_evt_code <= popcount(r_s2);
      r_evt_arb  <= r_s2[ARB_TAP];
    end
  end

  assign w_coarse_inc = r_coarse + COARSE_W'(1);

  // Arm/measure FSM with registered record and status outputs.
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state      <= S_IDLE;
      r_valid      <= 1'b0;
      r_start_code <= '0;
      r_stop_code  <= '0;
      r_coarse     <= '0;
      r_timeout    <= 1'b0;
      r_busy       <= 1'b0;
      r_arb_start  <= 1'b0;
      r_arb_stop   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iArm) begin
            r_state <= S_WAIT_START;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT_START: begin
          if (r_evt) begin
            r_state      <= S_WAIT_STOP;
            r_start_code <= r_evt_code;
            r_arb_start  <= r_evt_arb;
            r_coarse     <= '0;
            r_stop_code  <= '0;
            r_arb_stop   <= 1'b0;
            r_timeout    <= 1'b0;
          end
        end
        S_WAIT_STOP: begin
          r_coarse <= w_coarse_inc;
          if (r_evt) begin
            r_state     <= S_DONE;
            r_stop_code <= r_evt_code;
            r_arb_stop  <= r_evt_arb;
            r_valid     <= 1'b1;
          end else if (w_coarse_inc == {COARSE_W{1'b1}}) begin
            // Saturated coarse count closes the record with no stop code.
            r_state     <= S_DONE;
            r_stop_code <= '0;
            r_arb_stop  <= 1'b0;
            r_timeout   <= 1'b1;
            r_valid     <= 1'b1;
          end
        end
        S_DONE: begin
          // A concurrent arm is intentionally dropped on acceptance.
          if (iReady) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign oValid     = r_valid;
  assign oStartCode = r_start_code;
  assign oStopCode  = r_stop_code;
  assign oCoarse    = r_coarse;
  assign oTimeout   = r_timeout;
  assign oBusy      = r_busy;
  assign oArbStart  = r_arb_start;
  assign oArbStop   = r_arb_stop;

endmodule
`default_nettype wire

// File: tb/tb_tdc_fine_measure.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdc_fine_measure
//  Description : Directed self-checking bench for tdc_fine_measure. Tap words
//                are injected at the carry-chain output of the delay line.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_fine_measure;

  logic        clk;
  logic        rst_n;
  logic        hit, dbg_mode, dbg_hit, arm, ready;
  logic        valid, timeout, busy, arb_start, arb_stop;
  logic [6:0]  start_code, stop_code;
  logic [15:0] coarse;

  logic        arm4, ready4;
  logic        valid4, timeout4, busy4, arb_start4, arb_stop4;
  logic [6:0]  start_code4, stop_code4;
  logic [3:0]  coarse4;

  logic [63:0] tap_word;
  logic [63:0] tap_word4;

  int n_tests = 0;
  int n_fail  = 0;

  tdc_fine_measure #(.NUM_TAPS(64), .COARSE_W(16)) dut (
    .clk        (clk),
    .iRst_n     (rst_n),
    .iHit       (hit),
    .iDebugMode (dbg_mode),
    .iDebugHit  (dbg_hit),
    .iArm       (arm),
    .iReady     (ready),
    .oValid     (valid),
    .oStartCode (start_code),
    .oStopCode  (stop_code),
    .oCoarse    (coarse),
    .oTimeout   (timeout),
    .oBusy      (busy),
    .oArbStart  (arb_start),
    .oArbStop   (arb_stop)
  );

  tdc_fine_measure #(.NUM_TAPS(64), .COARSE_W(4)) dut4 (
    .clk        (clk),
    .iRst_n     (rst_n),
    .iHit       (1'b0),
    .iDebugMode (1'b0),
    .iDebugHit  (1'b0),
    .iArm       (arm4),
    .iReady     (ready4),
    .oValid     (valid4),
    .oStartCode (start_code4),
    .oStopCode  (stop_code4),
    .oCoarse    (coarse4),
    .oTimeout   (timeout4),
    .oBusy      (busy4),
    .oArbStart  (arb_start4),
    .oArbStop   (arb_stop4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait for a record on the selected instance.
  task automatic wait_valid(input bit sel, input int budget, input string tag);
    int i;
    i = 0;
    while (((sel ? valid4 : valid) !== 1'b1) && (i < budget)) begin
      @(negedge clk);
      i++;
    end
    check(tag, 64'(sel ? valid4 : valid), 64'd1);
  endtask

  // Single-cycle arm pulse on the main instance.
  task automatic arm_pulse();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; hit = 1'b0; dbg_mode = 1'b0; dbg_hit = 1'b0;
    arm = 1'b0; ready = 1'b0; arm4 = 1'b0; ready4 = 1'b0;
    tap_word = '0; tap_word4 = '0;
    force dut.u_delay_line.w_co  = tap_word;
    force dut4.u_delay_line.w_co = tap_word4;
    tick(3);

    // Reset state
    check("rst_valid",   64'(valid),      64'd0);
    check("rst_busy",    64'(busy),       64'd0);
    check("rst_start",   64'(start_code), 64'd0);
    check("rst_stop",    64'(stop_code),  64'd0);
    check("rst_coarse",  64'(coarse),     64'd0);
    check("rst_timeout", 64'(timeout),    64'd0);
    check("rst_arb",     64'({arb_start, arb_stop}), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Basic measurement: start 0xFFFF, stop 0x0FFF ten cycles later
    arm_pulse();
    check("t2_busy", 64'(busy), 64'd1);
    tap_word = 64'h0000_0000_0000_FFFF;
    tick(3);
    tap_word = '0;
    tick(7);
    tap_word = 64'h0000_0000_0000_0FFF;
    tick(3);
    tap_word = '0;
    wait_valid(1'b0, 50, "t2_valid");
    check("t2_start",   64'(start_code), 64'd16);
    check("t2_stop",    64'(stop_code),  64'd12);
    check("t2_coarse",  64'(coarse),     64'd10);
    check("t2_timeout", 64'(timeout),    64'd0);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("t2_valid_clr", 64'(valid), 64'd0);
    check("t2_idle",      64'(busy),  64'd0);

    // Bubble start word and all-ones stop word
    arm_pulse();
    tap_word = 64'h0000_0000_0000_00F7;
    tick(2);
    tap_word = '0;
    tick(3);
    tap_word = '1;
    tick(2);
    tap_word = '0;
    wait_valid(1'b0, 50, "t3_valid");
    check("t3_start",    64'(start_code), 64'd7);
    check("t3_stop",     64'(stop_code),  64'd64);
    check("t3_coarse",   64'(coarse),     64'd5);
    check("t3_arbstart", 64'(arb_start),  64'd0);
    check("t3_arbstop",  64'(arb_stop),   64'd1);

    // Backpressure: record held while further hits arrive
    for (int i = 0; i < 20; i++) begin
      tap_word = (i % 4 < 2) ? 64'h0000_0000_0000_00FF : 64'd0;
      tick(1);
    end
    tap_word = '0;
    check("t5_valid_hold", 64'(valid),      64'd1);
    check("t5_start_hold", 64'(start_code), 64'd7);
    check("t5_stop_hold",  64'(stop_code),  64'd64);
    check("t5_coarse_hold",64'(coarse),     64'd5);
    ready = 1'b1;
    arm   = 1'b1;
    tick(1);
    ready = 1'b0;
    arm   = 1'b0;
    check("t5_valid_clr", 64'(valid), 64'd0);
    check("t5_arm_drop",  64'(busy),  64'd0);
    tap_word = 64'h0000_0000_0000_00FF;
    tick(2);
    tap_word = '0;
    tick(10);
    check("t5_no_record", 64'(valid), 64'd0);

    // Asynchronous reset in the middle of a long measurement
    arm_pulse();
    tap_word = 64'h0000_0000_0000_00FF;
    tick(2);
    tap_word = '0;
    tick(39);
    check("t1_busy_pre",  64'(busy),  64'd1);
    check("t1_valid_pre", 64'(valid), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_async_busy",   64'(busy),       64'd0);
    check("t1_async_coarse", 64'(coarse),     64'd0);
    check("t1_async_start",  64'(start_code), 64'd0);
    check("t1_async_valid",  64'(valid),      64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    tap_word = 64'h0000_0000_0000_0FFF;
    tick(2);
    tap_word = '0;
    tick(4);
    tap_word = 64'h0000_0000_0000_0FFF;
    tick(2);
    tap_word = '0;
    tick(10);
    check("t1_need_arm_valid", 64'(valid), 64'd0);
    check("t1_need_arm_busy",  64'(busy),  64'd0);

    // Coarse saturation on the 4-bit instance
    arm4 = 1'b1;
    tick(1);
    arm4 = 1'b0;
    tap_word4 = 64'h0000_0001_FFFF_FFFF;
    tick(2);
    tap_word4 = '0;
    wait_valid(1'b1, 40, "t4_valid");
    check("t4_timeout",  64'(timeout4),    64'd1);
    check("t4_stop",     64'(stop_code4),  64'd0);
    check("t4_coarse",   64'(coarse4),     64'd15);
    check("t4_start",    64'(start_code4), 64'd33);
    check("t4_arbstart", 64'(arb_start4),  64'd1);
    ready4 = 1'b1;
    tick(1);
    ready4 = 1'b0;
    check("t4_valid_clr", 64'(valid4), 64'd0);

    // Debug hit source drives the real chain
    release dut.u_delay_line.w_co;
    dbg_mode = 1'b1;
    tick(2);
    arm_pulse();
    dbg_hit = 1'b1;
    tick(2);
    dbg_hit = 1'b0;
    tick(4);
    dbg_hit = 1'b1;
    tick(2);
    dbg_hit = 1'b0;
    wait_valid(1'b0, 50, "t6_valid");
    check("t6_start",  64'(start_code), 64'd64);
    check("t6_stop",   64'(stop_code),  64'd64);
    check("t6_coarse", 64'(coarse),     64'd6);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;

    // Normal mode with the debug hit parked high: only iHit counts
    dbg_mode = 1'b0;
    dbg_hit  = 1'b1;
    tick(2);
    arm_pulse();
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
    tick(2);
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
    wait_valid(1'b0, 40, "t6_hit_valid");
    check("t6_hit_coarse",  64'(coarse),  64'd3);
    check("t6_hit_timeout", 64'(timeout), 64'd0);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
